aes_wddl_unload: RTL and testbench

- Output-side converter for the WDDL AES datapath. Accepts the dual-rail (true/complement) state bytes the round logic produces, one byte per handshake.
- Checks rail integrity on every accepted byte. Collapses each byte to single rail and packs 16 bytes into a 128-bit text_out word.
- Presents the word to the single-rail host with a valid/ready handshake. It is the exit point where dual-rail encoding ends, the mirror of the ld_r load path where single-rail text enters the XOR stage.

---
 rtl/wddl_pkg.sv | 19 +
 rtl/wddl_rail_check.sv | 18 +
 rtl/aes_wddl_unload.sv | 112 +++++++++++
 tb/tb_aes_wddl_unload.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wddl_pkg.sv
// Shared dual-rail (WDDL) definitions: block geometry, unload FSM states and
// the per-bit complement check used by every rail-integrity monitor.
package wddl_pkg;

   localparam int unsigned AES_NBYTES = 16;
   localparam int unsigned BYTE_W     = 8;

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } state_e;

   // A bit pair is a valid evaluated value only when the rails disagree.
   function automatic logic [BYTE_W-1:0] dr_good(input logic [BYTE_W-1:0] p,
                                                 input logic [BYTE_W-1:0] n);
      return p ^ n;
   endfunction

endpackage

// File: rtl/wddl_rail_check.sv
// Combinational rail-integrity monitor for one dual-rail byte.
module wddl_rail_check
   import wddl_pkg::*;
(
   input  logic [BYTE_W-1:0] i_p,
   input  logic [BYTE_W-1:0] i_n,
   output logic              o_fault,
   output logic              o_precharge
);

   logic [BYTE_W-1:0] w_good;

   assign w_good      = dr_good(i_p, i_n);
   // Any 00 or 11 pair makes the byte unusable as an evaluated value.
   assign o_fault     = ~&w_good;
   assign o_precharge = ~|(i_p | i_n);

endmodule

// File: rtl/aes_wddl_unload.sv
// Exit point of the WDDL AES datapath: checks and collapses dual-rail state
// bytes, packs them into a 128-bit block and hands it to the single-rail host.
module aes_wddl_unload
   import wddl_pkg::*;
#(
   parameter int unsigned NBYTES          = AES_NBYTES,
   parameter bit          CHECK_PRECHARGE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BYTE_W-1:0]        sa_i,
   input  logic [BYTE_W-1:0]        sa_i_n,
   input  logic                     byte_vld,
   output logic                     byte_rdy,
   output logic [BYTE_W*NBYTES-1:0] text_out,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic                     rail_err,
   output logic                     err_sticky
);

   localparam int unsigned    IDX_W    = $clog2(NBYTES);
   localparam int unsigned    TEXT_W   = BYTE_W * NBYTES;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_e              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [TEXT_W-1:0]   r_text;
   logic                r_out_vld;
   logic                r_rail_err;
   logic                r_err_sticky;
   logic                r_blk_fault;
   logic                r_byte_rdy;

   logic                w_rc_fault;
   logic                w_rc_precharge;
   logic                w_accept;
   logic                w_byte_fault;
   logic                w_pre_fault;
   logic                w_fault;

   wddl_rail_check u_rail_check (
      .i_p         (sa_i),
      .i_n         (sa_i_n),
      .o_fault     (w_rc_fault),
      .o_precharge (w_rc_precharge)
   );

   assign w_accept     = byte_vld & r_byte_rdy;
   assign w_byte_fault = w_accept & w_rc_fault;
   // Between bytes the rails must sit in precharge while a block is filling.
   assign w_pre_fault  = CHECK_PRECHARGE & (r_state == COLLECT) & ~byte_vld & ~w_rc_precharge;
   assign w_fault      = w_byte_fault | w_pre_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= COLLECT;
         r_idx        <= '0;
         r_text       <= '0;
         r_out_vld    <= 1'b0;
         r_rail_err   <= 1'b0;
         r_err_sticky <= 1'b0;
         r_blk_fault  <= 1'b0;
         r_byte_rdy   <= 1'b1;
      end else begin
         if (w_fault) begin
            r_err_sticky <= 1'b1;
         end
         case (r_state)
            COLLECT: begin
               if (w_fault) begin
                  r_blk_fault <= 1'b1;
               end
               if (w_accept) begin
                  // True rail is stored even for a faulty byte.
                  for (int unsigned l = 0; l < NBYTES; l++) begin
                     if (r_idx == IDX_W'(l)) begin
                        r_text[TEXT_W-1-BYTE_W*l -: BYTE_W] <= sa_i;
                     end
                  end
                  if (r_idx == LAST_IDX) begin
                     r_idx      <= '0;
                     r_state    <= DONE;
                     r_out_vld  <= 1'b1;
                     r_rail_err <= r_blk_fault | w_fault;
                     r_byte_rdy <= 1'b0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            DONE: begin
               // text_out is left as-is; the next block overwrites lane by lane.
               if (out_rdy) begin
                  r_state     <= COLLECT;
                  r_out_vld   <= 1'b0;
                  r_rail_err  <= 1'b0;
                  r_blk_fault <= 1'b0;
                  r_byte_rdy  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign byte_rdy   = r_byte_rdy;
   assign text_out   = r_text;
   assign out_vld    = r_out_vld;
   assign rail_err   = r_rail_err;
   assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_aes_wddl_unload.sv
// Directed bench for aes_wddl_unload; a second instance runs with the
// precharge check disabled for the idle-glitch comparison.
module tb_aes_wddl_unload;

   logic         clk;
   logic         rst;
   logic [7:0]   sa_i;
   logic [7:0]   sa_i_n;
   logic         byte_vld;
   logic         out_rdy;

   logic         byte_rdy,   np_byte_rdy;
   logic [127:0] text_out,   np_text_out;
   logic         out_vld,    np_out_vld;
   logic         rail_err,   np_rail_err;
   logic         err_sticky, np_err_sticky;

   int n_cmp = 0;
   int n_err = 0;

   aes_wddl_unload #(.NBYTES(16), .CHECK_PRECHARGE(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .sa_i       (sa_i),
      .sa_i_n     (sa_i_n),
      .byte_vld   (byte_vld),
      .byte_rdy   (byte_rdy),
      .text_out   (text_out),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .rail_err   (rail_err),
      .err_sticky (err_sticky)
   );

   aes_wddl_unload #(.NBYTES(16), .CHECK_PRECHARGE(1'b0)) dut_np (
      .clk        (clk),
      .rst        (rst),
      .sa_i       (sa_i),
      .sa_i_n     (sa_i_n),
      .byte_vld   (byte_vld),
      .byte_rdy   (np_byte_rdy),
      .text_out   (np_text_out),
      .out_vld    (np_out_vld),
      .out_rdy    (out_rdy),
      .rail_err   (np_rail_err),
      .err_sticky (np_err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One byte per call; consecutive calls give back-to-back bytes.
   task automatic send_byte(input logic [7:0] p, input logic [7:0] n);
      sa_i     = p;
      sa_i_n   = n;
      byte_vld = 1'b1;
      @(posedge clk); #1;
      sa_i     = '0;
      sa_i_n   = '0;
      byte_vld = 1'b0;
   endtask

   task automatic handshake();
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sa_i = '0; sa_i_n = '0; byte_vld = 1'b0; out_rdy = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      chk("rst_text",   text_out,   128'h0);
      chk("rst_vld",    out_vld,    1'b0);
      chk("rst_err",    rail_err,   1'b0);
      chk("rst_sticky", err_sticky, 1'b0);
      chk("rst_rdy",    byte_rdy,   1'b1);

      // Clean block 0x00..0x0F
      for (int i = 0; i < 16; i++) send_byte(8'(i), ~8'(i));
      chk("b1_vld",  out_vld,  1'b1);
      chk("b1_text", text_out, 128'h000102030405060708090A0B0C0D0E0F);
      chk("b1_err",  rail_err, 1'b0);
      chk("b1_rdy",  byte_rdy, 1'b0);

      // Host stalls; stray byte_vld pulses must be ignored
      for (int c = 0; c < 5; c++) begin
         sa_i = 8'hEE; sa_i_n = 8'h11; byte_vld = 1'b1;
         @(posedge clk); #1;
         chk("hold_vld",  out_vld,  1'b1);
         chk("hold_text", text_out, 128'h000102030405060708090A0B0C0D0E0F);
         chk("hold_rdy",  byte_rdy, 1'b0);
      end
      sa_i = '0; sa_i_n = '0; byte_vld = 1'b0;
      handshake();
      chk("hs_vld", out_vld,  1'b0);
      chk("hs_rdy", byte_rdy, 1'b1);

      // Next block: lane 0 overwritten first, rest keeps old data; byte 7 faulty
      send_byte(8'h80, 8'h7F);
      chk("lane0_text", text_out, 128'h800102030405060708090A0B0C0D0E0F);
      for (int i = 1; i < 16; i++) begin
         if (i == 7) send_byte(8'hA5, 8'h5B);
         else        send_byte(8'(8'h10 + i), ~8'(8'h10 + i));
      end
      chk("b2_vld",    out_vld,    1'b1);
      chk("b2_text",   text_out,   128'h80111213141516A5_18191A1B1C1D1E1F);
      chk("b2_err",    rail_err,   1'b1);
      chk("b2_sticky", err_sticky, 1'b1);
      handshake();

      // Clean block after a faulty one
      for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), ~8'(8'h20 + i));
      chk("b3_text",   text_out,   128'h202122232425262728292A2B2C2D2E2F);
      chk("b3_err",    rail_err,   1'b0);
      chk("b3_sticky", err_sticky, 1'b1);
      handshake();

      // Rails not precharged during an idle cycle mid-block
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(8'h30 + i), ~8'(8'h30 + i));
         if (i == 4) begin
            sa_i = 8'h01; sa_i_n = 8'h00;
            @(posedge clk); #1;
            sa_i = '0;
         end
      end
      chk("pc_text",    text_out,    128'h303132333435363738393A3B3C3D3E3F);
      chk("pc_err",     rail_err,    1'b1);
      chk("npc_text",   np_text_out, 128'h303132333435363738393A3B3C3D3E3F);
      chk("npc_err",    np_rail_err, 1'b0);
      handshake();

      // Reset mid-block discards the partial block
      for (int i = 0; i < 9; i++) send_byte(8'(8'h40 + i), ~8'(8'h40 + i));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_vld",    out_vld,    1'b0);
      chk("mrst_text",   text_out,   128'h0);
      chk("mrst_sticky", err_sticky, 1'b0);
      chk("mrst_rdy",    byte_rdy,   1'b1);
      for (int i = 0; i < 15; i++) send_byte(8'(8'hFF - i), 8'(i));
      chk("b5_early_vld", out_vld, 1'b0);
      send_byte(8'hF0, 8'h0F);
      chk("b5_vld",  out_vld,  1'b1);
      chk("b5_text", text_out, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
      chk("b5_err",  rail_err, 1'b0);
      handshake();

      // Precharged byte accepted at lane 3; last byte carries 11 pairs
      for (int i = 0; i < 16; i++) begin
         if (i == 3)       send_byte(8'h00, 8'h00);
         else if (i == 15) send_byte(8'hFF, 8'hFF);
         else              send_byte(8'(8'h50 + i), ~8'(8'h50 + i));
      end
      chk("b6_text",   text_out,   128'h50515200_54555657_58595A5B_5C5D5EFF);
      chk("b6_err",    rail_err,   1'b1);
      chk("b6_sticky", err_sticky, 1'b1);
      handshake();
      chk("b6_hs_vld", out_vld, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
